// File: rtl/apb_bridge_arbiter_if.sv
// Bundle shared by the requesters, the arbiter and the AHB-to-APB bridge port.
// master = arbiter view; slave = requester/bridge environment view.
interface apb_bridge_arbiter_if #(
  parameter int NREQ        = 4,
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [NREQ-1:0]                        req;
  logic [NREQ-1:0][HADDR_WIDTH-1:0]       req_addr;
  logic [NREQ-1:0]                        req_write;
  logic [NREQ-1:0][DATA_WIDTH-1:0]        req_wdata;
  logic [NREQ-1:0][DATA_WIDTH/8-1:0]      req_wstrb;
  logic [NREQ-1:0]                        gnt;
  logic [NREQ-1:0]                        ack;
  logic                                   rsp_err;
  logic [DATA_WIDTH-1:0]                  rsp_rdata;
  logic                                   m_hsel;
  logic [1:0]                             m_htrans;
  logic [HADDR_WIDTH-1:0]                 m_haddr;
  logic                                   m_hwrite;
  logic [DATA_WIDTH-1:0]                  m_hwdata;
  logic [DATA_WIDTH/8-1:0]                m_hwstrb;
  logic [2:0]                             m_hsize;
  logic [2:0]                             m_hburst;
  logic                                   m_hready_i;
  logic                                   m_hresp_i;
  logic [DATA_WIDTH-1:0]                  m_hrdata_i;

  modport master (
    input  req, req_addr, req_write, req_wdata, req_wstrb,
    output gnt, ack, rsp_err, rsp_rdata,
    output m_hsel, m_htrans, m_haddr, m_hwrite, m_hwdata, m_hwstrb, m_hsize, m_hburst,
    input  m_hready_i, m_hresp_i, m_hrdata_i
  );

  modport slave (
    output req, req_addr, req_write, req_wdata, req_wstrb,
    input  gnt, ack, rsp_err, rsp_rdata,
    input  m_hsel, m_htrans, m_haddr, m_hwrite, m_hwdata, m_hwstrb, m_hsize, m_hburst,
    output m_hready_i, m_hresp_i, m_hrdata_i
  );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// Round-robin sequencer sharing one AHB-lite bridge port among NREQ requesters,
// with a post-transfer idle gap and a watchdog on stalled transfers.
module apb_bridge_arbiter #(
  parameter int NREQ        = 4,
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 256
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  apb_bridge_arbiter_if.master  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam int TO_LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [15:0] TO_LAST  = TO_LAST_I[15:0];
  localparam logic [15:0] GAP_LAST = GAP_LAST_I[15:0];

  typedef enum logic [1:0] {IDLE, XFER, RESP, GAP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, ptr_q, ptr_d, pick;
  logic [IW:0]             sum;
  logic                    found, timeout_hit;
  logic [15:0]             wdog_q, wdog_d, gap_q, gap_d;
  logic [HADDR_WIDTH-1:0]  haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
  logic [SW-1:0]           hwstrb_q, hwstrb_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [NREQ-1:0]         gnt_q, ack_q, sel_d;
  logic                    hsel_q;
  logic [1:0]              htrans_q;

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && bus.req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    wdog_d      = wdog_q;
    gap_d       = gap_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    hwstrb_d    = hwstrb_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: if (found) begin
        state_d  = XFER;
        idx_d    = pick;
        haddr_d  = bus.req_addr[pick];
        hwrite_d = bus.req_write[pick];
        hwdata_d = bus.req_wdata[pick];
        hwstrb_d = bus.req_wstrb[pick];
        wdog_d   = '0;
      end
      XFER: begin
        wdog_d = wdog_q + 16'd1;
        // Bridge completion takes priority over a coincident watchdog expiry.
        if (bus.m_hready_i) begin
          state_d     = RESP;
          rsp_err_d   = bus.m_hresp_i;
          rsp_rdata_d = hwrite_q ? '0 : bus.m_hrdata_i;
        end else if (timeout_hit) begin
          state_d     = RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_d = {{(NREQ-1){1'b0}}, 1'b1} << idx_d;

  // Bus-facing outputs are registered from the next state so they change on the edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      wdog_q      <= '0;
      gap_q       <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      hwstrb_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      hwstrb_q    <= hwstrb_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      gnt_q       <= (state_d == XFER || state_d == RESP) ? sel_d : '0;
      ack_q       <= (state_d == RESP) ? sel_d : '0;
      hsel_q      <= (state_d == XFER);
      htrans_q    <= (state_d == XFER) ? 2'b10 : 2'b00;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.m_hsel    = hsel_q;
  assign bus.m_htrans  = htrans_q;
  assign bus.m_haddr   = haddr_q;
  assign bus.m_hwrite  = hwrite_q;
  assign bus.m_hwdata  = hwdata_q;
  assign bus.m_hwstrb  = hwstrb_q;
  assign bus.m_hsize   = 3'($clog2(SW));
  assign bus.m_hburst  = 3'b000;
endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench: the bench plays all requesters and the bridge, checking
// grants, held command, responses, gaps, watchdog and reset behaviour.
module tb_apb_bridge_arbiter;
  logic hclk = 1'b0;
  logic hresetn;
  int   checks = 0;
  int   failures = 0;

  always #5 hclk = ~hclk;

  apb_bridge_arbiter_if #(.NREQ(4), .HADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_bridge_arbiter #(
    .NREQ(4), .HADDR_WIDTH(32), .DATA_WIDTH(32), .GAP_CYCLES(2), .TIMEOUT(8)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},    bus.gnt, 0);
    chk({tag, "_ack"},    bus.ack, 0);
    chk({tag, "_err"},    bus.rsp_err, 0);
    chk({tag, "_rdata"},  bus.rsp_rdata, 0);
    chk({tag, "_hsel"},   bus.m_hsel, 0);
    chk({tag, "_htrans"}, bus.m_htrans, 0);
    chk({tag, "_haddr"},  bus.m_haddr, 0);
    chk({tag, "_hwrite"}, bus.m_hwrite, 0);
    chk({tag, "_hwdata"}, bus.m_hwdata, 0);
    chk({tag, "_hwstrb"}, bus.m_hwstrb, 0);
    chk({tag, "_hsize"},  bus.m_hsize, 3'd2);
    chk({tag, "_hburst"}, bus.m_hburst, 3'd0);
  endtask

  task automatic wait_hsel(input string tag);
    int n = 0;
    while (bus.m_hsel !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_hsel_seen"}, bus.m_hsel, 1'b1);
  endtask

  // Bridge model: completes after lat extra XFER cycles, checking the held command.
  task automatic serve(input string tag, input int lat, input logic resp,
                       input logic [31:0] rdata, input logic [3:0] exp_gnt,
                       input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] ws, output int hi);
    wait_hsel(tag);
    hi = 0;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) step();
      if (bus.m_hsel === 1'b1) hi++;
      chk({tag, "_gnt"},    bus.gnt, exp_gnt);
      chk({tag, "_htrans"}, bus.m_htrans, 2'b10);
      chk({tag, "_haddr"},  bus.m_haddr, a);
      chk({tag, "_hwrite"}, bus.m_hwrite, w);
      chk({tag, "_hwdata"}, bus.m_hwdata, wd);
      chk({tag, "_hwstrb"}, bus.m_hwstrb, ws);
    end
    bus.m_hready_i = 1'b1;
    bus.m_hresp_i  = resp;
    bus.m_hrdata_i = rdata;
    step();
    bus.m_hready_i = 1'b0;
    bus.m_hresp_i  = 1'b0;
    bus.m_hrdata_i = 32'h0BAD_0000;
  endtask

  task automatic apply_reset();
    hresetn = 1'b0;
    step();
    step();
    hresetn = 1'b1;
  endtask

  initial begin
    int hi, n;
    logic [3:0] oh;
    hresetn        = 1'b0;
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.req_write  = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.m_hready_i = 1'b0;
    bus.m_hresp_i  = 1'b0;
    bus.m_hrdata_i = '0;
    repeat (3) step();
    check_zero("reset");
    hresetn = 1'b1;
    step();

    // 1: single read from requester 0
    bus.req_addr[0] = 32'h4001_0004;
    bus.req = 4'b0001;
    serve("t1", 3, 1'b0, 32'hA5A5_1234, 4'b0001, 32'h4001_0004, 1'b0, 32'h0, 4'h0, hi);
    chk("t1_hsel_cycles", hi, 4);
    chk("t1_ack",    bus.ack, 4'b0001);
    chk("t1_gnt",    bus.gnt, 4'b0001);
    chk("t1_hsel0",  bus.m_hsel, 1'b0);
    chk("t1_rdata",  bus.rsp_rdata, 32'hA5A5_1234);
    chk("t1_err",    bus.rsp_err, 1'b0);
    bus.req = 4'b0000;
    step();
    chk("t1_ack_once",  bus.ack, 4'b0000);
    chk("t1_rdata_hold", bus.rsp_rdata, 32'hA5A5_1234);
    chk("t1_gnt_off",   bus.gnt, 4'b0000);

    // 2: all four requesting, round-robin from pointer 0
    apply_reset();
    for (int i = 0; i < 4; i++) bus.req_addr[i] = 32'h1000 + 32'(i * 4);
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      oh = 4'b0001 << (t % 4);
      serve("t2", 0, 1'b0, 32'h100 + 32'(t), oh, 32'h1000 + 32'((t % 4) * 4),
            1'b0, 32'h0, 4'h0, hi);
      chk("t2_ack",   bus.ack, oh);
      chk("t2_rdata", bus.rsp_rdata, 32'h100 + 32'(t));
      if (t == 4) bus.req = 4'b0000;
      for (int g = 0; g < 2; g++) begin
        step();
        chk("t2_gap_hsel", bus.m_hsel, 1'b0);
        chk("t2_gap_ack",  bus.ack, 4'b0000);
      end
    end

    // 3: write from requester 2, command held until hready
    bus.req_addr[2]  = 32'h2000_0008;
    bus.req_write[2] = 1'b1;
    bus.req_wdata[2] = 32'hDEAD_BEEF;
    bus.req_wstrb[2] = 4'b0011;
    bus.req = 4'b0100;
    serve("t3", 2, 1'b0, 32'h1234_5678, 4'b0100, 32'h2000_0008, 1'b1,
          32'hDEAD_BEEF, 4'b0011, hi);
    chk("t3_ack",   bus.ack, 4'b0100);
    chk("t3_rdata", bus.rsp_rdata, 32'h0);
    chk("t3_err",   bus.rsp_err, 1'b0);
    bus.req = 4'b0000;
    bus.req_write[2] = 1'b0;

    // 4: bridge never ready, watchdog fires after 8 cycles
    bus.req_addr[1] = 32'h3000_0000;
    bus.req = 4'b0010;
    bus.m_hrdata_i = 32'hFFFF_FFFF;
    wait_hsel("t4");
    hi = 0;
    n = 0;
    while (bus.m_hsel === 1'b1 && n < 30) begin
      hi++;
      step();
      n++;
    end
    chk("t4_hsel_cycles", hi, 8);
    chk("t4_ack",   bus.ack, 4'b0010);
    chk("t4_err",   bus.rsp_err, 1'b1);
    chk("t4_rdata", bus.rsp_rdata, 32'h0);
    bus.req_addr[3] = 32'h3000_0010;
    bus.req = 4'b1000;
    serve("t4b", 1, 1'b0, 32'hCAFE_0003, 4'b1000, 32'h3000_0010, 1'b0, 32'h0, 4'h0, hi);
    chk("t4b_ack",   bus.ack, 4'b1000);
    chk("t4b_err",   bus.rsp_err, 1'b0);
    chk("t4b_rdata", bus.rsp_rdata, 32'hCAFE_0003);

    // 5: bridge error response, then hready coinciding with watchdog expiry
    bus.req_addr[0] = 32'h5000_0000;
    bus.req = 4'b0001;
    serve("t5a", 1, 1'b1, 32'h0000_0077, 4'b0001, 32'h5000_0000, 1'b0, 32'h0, 4'h0, hi);
    chk("t5a_ack",   bus.ack, 4'b0001);
    chk("t5a_err",   bus.rsp_err, 1'b1);
    chk("t5a_rdata", bus.rsp_rdata, 32'h77);
    serve("t5b", 7, 1'b0, 32'h0000_0088, 4'b0001, 32'h5000_0000, 1'b0, 32'h0, 4'h0, hi);
    chk("t5b_hsel_cycles", hi, 8);
    chk("t5b_ack",   bus.ack, 4'b0001);
    chk("t5b_err",   bus.rsp_err, 1'b0);
    chk("t5b_rdata", bus.rsp_rdata, 32'h88);
    bus.req = 4'b0000;

    // 6: reset in the middle of a transfer
    bus.req = 4'b1000;
    wait_hsel("t6");
    step();
    hresetn = 1'b0;
    #1;
    check_zero("t6_rst");
    step();
    chk("t6_no_ack", bus.ack, 4'b0000);
    hresetn = 1'b1;
    wait_hsel("t6b");
    chk("t6b_gnt", bus.gnt, 4'b1000);
    hresetn = 1'b0;
    #1;
    bus.req = 4'b1001;
    step();
    hresetn = 1'b1;
    wait_hsel("t6c");
    chk("t6c_gnt", bus.gnt, 4'b0001);
    chk("t6c_ack", bus.ack, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
